enemy_wave: RTL and testbench
=============================

Name: enemy_wave

Overview:
- Generates the `damage` and `hit` single-cycle event pulses that the player life/money block consumes.
- Drives one enemy down a 16-cell lane toward the player:
  - Enemy reaches the player → `damage` pulse.
  - Player attacks while the enemy is inside the hit zone → `hit` pulse.
- Respawn delays are pseudo-random (LFSR).
- Sits between the debounced button/one-pulse logic and the player block; its lane output drives the LED row.

Parameters:
- STEP_TICKS, 25000000, clk cycles per enemy step at base speed.
- MIN_STEP_TICKS, 6250000, floor on step period when speed-up is active.
- HIT_ZONE, 3, enemy positions 0..HIT_ZONE are attackable.
- LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit LFSR.
- RESPAWN_BASE, 12500000, minimum respawn delay in cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- attack  input  1  one-cycle attack request (already debounced/one-pulsed)
- game_over  input  1  level; high when player life is 0, freezes the game
- damage  output  1  one-cycle pulse: enemy reached the player
- hit  output  1  one-cycle pulse: enemy defeated
- lane  output  16  one-hot enemy position; bit15 = far end, bit0 = adjacent to player; 0 when no enemy
- kills  output  8  saturating defeated-enemy count (0..255)

Behaviour:
- Reset (rst_n low, async):
  - state = SPAWN_WAIT
  - damage = 0, hit = 0, lane = 0, kills = 0
  - LFSR = LFSR_SEED
  - step period = STEP_TICKS
  - wait counter loaded with RESPAWN_BASE
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in every state except HALT. Never zero.
- States:
  - SPAWN_WAIT:
    - wait counter decrements each cycle.
    - At 0: pos = 15, tick counter = 0, lane = 1<<15, → ADVANCE.
  - ADVANCE:
    - Tick counter increments. When it reaches step period−1, it clears and pos decrements.
    - pos == 0 and step expires → damage = 1 for exactly that cycle, lane = 0, reload wait, → SPAWN_WAIT.
    - attack == 1 and pos <= HIT_ZONE → hit = 1 next cycle, kills += 1 (saturate at 255), lane = 0, reload wait, → SPAWN_WAIT.
    - attack with pos > HIT_ZONE → ignored, no penalty.
  - HALT:
    - Entered from any state the cycle after game_over is sampled high.
    - lane, kills frozen; no pulses; counters hold.
    - Leaves only on reset.
- Wait reload value: RESPAWN_BASE + {LFSR[7:0], 16'd0}, computed as a 32-bit sum.
- Pulse latency:
  - damage/hit are registered, asserted exactly 1 cycle, never both in the same cycle.
  - The cycle after either pulse the state is SPAWN_WAIT and lane = 0.
- Simultaneous events:
  - attack in the same cycle as the pos-0 step expiry → hit wins, no damage.
  - game_over in the same cycle as a qualifying attack or expiry → event still pulses once, then HALT.
- attack held high across multiple cycles counts as one hit per enemy: the enemy is gone after the first.

Optional Feature:
- SPEEDUP_EN defined: every 8th kill, step period -= step period>>2, clamped at MIN_STEP_TICKS. Applied at the next spawn.
- Not defined: step period fixed at STEP_TICKS; MIN_STEP_TICKS unused.

Decomposition:
- Shared package holds:
  - state enum {SPAWN_WAIT, ADVANCE, HALT}
  - LANE_W = 16
  - LFSR tap constant
  - default timing constants, shared with the player/top-level so the game's timing is tuned in one place
- One natural sub-module: lfsr16 (clk, rst_n, en, q[15:0]), reusable for other random game events.

Test Plan:
- Bench setup: STEP_TICKS=4, RESPAWN_BASE=8, LFSR_SEED=16'h0001.
1. Reset release, no attack → lane = 0 until wait expires, then 16'h8000. After 16 steps of 4 cycles, damage pulses exactly 1 cycle, then lane = 0.
2. Attack while lane = 16'h0400 (pos 10) → no hit, enemy continues. Attack at pos 2 → hit 1 cycle, kills = 1, lane = 0 next cycle.
3. Attack in the same cycle as the pos-0 step expiry → hit = 1, damage stays 0, kills increments.
4. Assert game_over mid-ADVANCE at pos 7 → lane holds 16'h0080 forever, no pulses, attack ignored. Assert rst_n low → all outputs 0 immediately (async).
5. With SPEEDUP_EN, STEP_TICKS=16, MIN_STEP_TICKS=8 → after 8 kills, step period 12; after 16 kills, 9; after 24 kills, clamped to 8. Without the macro → stays 16.
6. Kill 256 enemies → kills saturates at 255, hit still pulses on each kill.

Source files
------------

// File: rtl/enemy_wave_pkg.sv
// Shared types and default timing constants for the enemy lane game.
// Tune game timing here so the player block and this block stay consistent.
package enemy_wave_pkg;
  typedef enum logic [1:0] {SPAWN_WAIT, ADVANCE, HALT} state_t;

  localparam int LANE_W = 16;
  // Fibonacci taps 16,14,13,11 as a mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int          STEP_TICKS_DEF     = 25000000;
  localparam int          MIN_STEP_TICKS_DEF = 6250000;
  localparam int          HIT_ZONE_DEF       = 3;
  localparam logic [15:0] LFSR_SEED_DEF      = 16'hACE1;
  localparam int          RESPAWN_BASE_DEF   = 12500000;
  localparam int          JITTER_SHIFT_DEF   = 16;

  function automatic logic [31:0] sped_up_period(input logic [31:0] p, input logic [31:0] floor_p);
    logic [31:0] n;
    n = p - (p >> 2);
    return (n < floor_p) ? floor_p : n;
  endfunction
endpackage

// File: rtl/enemy_wave_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts while en is high; seed must be nonzero.
// Reusable for any pseudo-random game event.
module lfsr16
  import enemy_wave_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);
  logic [15:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_reg <= SEED;
    else if (en) q_reg <= {q_reg[14:0], ^(q_reg & LFSR_TAPS)};
  end

  assign q = q_reg;
endmodule

// File: rtl/enemy_wave.sv
// One enemy walking a 16-cell lane; emits registered damage/hit pulses.
// Optional SPEEDUP_EN: step period shrinks by a quarter every 8th kill.
module enemy_wave
  import enemy_wave_pkg::*;
#(
  parameter int          STEP_TICKS     = STEP_TICKS_DEF,
  parameter int          MIN_STEP_TICKS = MIN_STEP_TICKS_DEF,
  parameter int          HIT_ZONE       = HIT_ZONE_DEF,
  parameter logic [15:0] LFSR_SEED      = LFSR_SEED_DEF,
  parameter int          RESPAWN_BASE   = RESPAWN_BASE_DEF,
  parameter int          JITTER_SHIFT   = JITTER_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              attack,
  input  logic              game_over,
  output logic              damage,
  output logic              hit,
  output logic [LANE_W-1:0] lane,
  output logic [7:0]        kills
);
  localparam logic [3:0] HIT_POS = 4'(HIT_ZONE);

  state_t            state_reg, state_next;
  logic [3:0]        pos_reg, pos_next;
  logic [31:0]       tick_reg, tick_next;
  logic [31:0]       wait_reg, wait_next;
  logic [31:0]       period_reg, period_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [7:0]        kills_reg, kills_next;
  logic              damage_reg, damage_next, hit_reg, hit_next;
  logic [15:0]       lfsr_q;
  logic              step_done, kill_ev, reach_ev;
  logic [31:0]       reload;
  logic              unused_ok;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_reg != HALT),
    .q    (lfsr_q)
  );

  assign reload    = 32'(RESPAWN_BASE) + (32'(lfsr_q[7:0]) << JITTER_SHIFT);
  assign step_done = (tick_reg == period_reg - 32'd1);
  // attack has priority over a simultaneous pos-0 expiry
  assign kill_ev   = (state_reg == ADVANCE) && attack && (pos_reg <= HIT_POS);
  assign reach_ev  = (state_reg == ADVANCE) && step_done && (pos_reg == 4'd0) && !kill_ev;
  assign unused_ok = ^{lfsr_q[15:8], 32'(MIN_STEP_TICKS)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= SPAWN_WAIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SPAWN_WAIT: if (wait_reg == 32'd0) state_next = ADVANCE;
      ADVANCE:    if (kill_ev || reach_ev) state_next = SPAWN_WAIT;
      default:    state_next = HALT;
    endcase
    if (game_over) state_next = HALT;
  end

  always_comb begin
    pos_next    = pos_reg;
    tick_next   = tick_reg;
    wait_next   = wait_reg;
    period_next = period_reg;
    lane_next   = lane_reg;
    kills_next  = kills_reg;
    damage_next = 1'b0;
    hit_next    = 1'b0;
    case (state_reg)
      SPAWN_WAIT: begin
        if (wait_reg == 32'd0) begin
          pos_next  = 4'(LANE_W - 1);
          tick_next = 32'd0;
          lane_next = {1'b1, {(LANE_W-1){1'b0}}};
        end else begin
          wait_next = wait_reg - 32'd1;
        end
      end
      ADVANCE: begin
        if (kill_ev) begin
          hit_next  = 1'b1;
          lane_next = '0;
          wait_next = reload;
          if (kills_reg != 8'hFF) begin
            kills_next = kills_reg + 8'd1;
`ifdef SPEEDUP_EN
            if (kills_reg[2:0] == 3'd7)
              period_next = sped_up_period(period_reg, 32'(MIN_STEP_TICKS));
`endif
          end
        end else if (reach_ev) begin
          damage_next = 1'b1;
          lane_next   = '0;
          wait_next   = reload;
        end else if (step_done) begin
          tick_next = 32'd0;
          pos_next  = pos_reg - 4'd1;
          lane_next = lane_reg >> 1;
        end else begin
          tick_next = tick_reg + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg    <= 4'd0;
      tick_reg   <= 32'd0;
      wait_reg   <= 32'(RESPAWN_BASE);
      period_reg <= 32'(STEP_TICKS);
      lane_reg   <= '0;
      kills_reg  <= 8'd0;
      damage_reg <= 1'b0;
      hit_reg    <= 1'b0;
    end else begin
      pos_reg    <= pos_next;
      tick_reg   <= tick_next;
      wait_reg   <= wait_next;
      period_reg <= period_next;
      lane_reg   <= lane_next;
      kills_reg  <= kills_next;
      damage_reg <= damage_next;
      hit_reg    <= hit_next;
    end
  end

  assign damage = damage_reg;
  assign hit    = hit_reg;
  assign lane   = lane_reg;
  assign kills  = kills_reg;
endmodule

// File: tb/tb_enemy_wave.sv
// Scoreboard bench for enemy_wave: stimulus pushes expected pulses, a monitor pops them.
// Small timing: STEP_TICKS=4, RESPAWN_BASE=8, seed 1, jitter shift 0 to keep runs short.
module tb_enemy_wave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        attack = 1'b0;
  logic        game_over = 1'b0;
  logic        damage, hit;
  logic [15:0] lane;
  logic [7:0]  kills;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       dmg;
    logic [7:0] kills;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  enemy_wave #(
    .STEP_TICKS    (4),
    .MIN_STEP_TICKS(3),
    .HIT_ZONE      (3),
    .LFSR_SEED     (16'h0001),
    .RESPAWN_BASE  (8),
    .JITTER_SHIFT  (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .attack   (attack),
    .game_over(game_over),
    .damage   (damage),
    .hit      (hit),
    .lane     (lane),
    .kills    (kills)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic wait_lane(input logic [15:0] v, input int max_cyc, output int n);
    n = 0;
    while (lane !== v && n < max_cyc) begin
      tick();
      n++;
    end
    if (lane !== v) begin
      checks++;
      failures++;
      $display("FAIL wait_lane timeout actual=0x%0h required=0x%0h", lane, v);
    end
  endtask

  function automatic int exp_period(input int k);
`ifdef SPEEDUP_EN
    return (k >= 8) ? 3 : 4;
`else
    return 4;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && (hit || damage)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual hit=%0b damage=%0b kills=%0d required none", hit, damage, kills);
      end else begin
        mon_e = exp_q.pop_front();
        if (damage !== mon_e.dmg || hit !== !mon_e.dmg || kills !== mon_e.kills) begin
          failures++;
          $display("FAIL event actual hit=%0b damage=%0b kills=%0d required hit=%0b damage=%0b kills=%0d",
                   hit, damage, kills, !mon_e.dmg, mon_e.dmg, mon_e.kills);
        end else begin
          $display("ev   %s kills=%0d", mon_e.dmg ? "damage" : "hit", kills);
        end
      end
    end
  end

  initial begin
    int n;
    int per;
    tick();
    check({lane, kills, hit, damage} == 26'd0, "reset_outputs", {lane, kills, hit, damage}, 0);
    rst_n = 1'b1;

    // 1: first spawn, full walk, damage
    wait_lane(16'h8000, 50, n);
    check(n == 9, "spawn_latency", n, 9);
    wait_lane(16'h0001, 100, n);
    check(n == 60, "walk_to_pos0", n, 60);
    exp_q.push_back('{dmg: 1'b1, kills: 8'd0});
    n = 0;
    while (damage !== 1'b1 && n < 20) begin tick(); n++; end
    check(n == 4, "damage_latency", n, 4);
    check(lane == 16'h0 && hit == 1'b0, "damage_lane_clear", {lane, hit}, 0);
    tick();
    check(damage == 1'b0 && lane == 16'h0, "damage_one_cycle", {damage, lane}, 0);

    // 2: attack out of zone ignored, in zone hits
    wait_lane(16'h0400, 600, n);
    attack = 1'b1; tick(); attack = 1'b0;
    check(hit == 1'b0 && lane == 16'h0400, "attack_far_ignored", {hit, lane}, 16'h0400);
    wait_lane(16'h0004, 100, n);
    exp_q.push_back('{dmg: 1'b0, kills: 8'd1});
    attack = 1'b1; tick(); attack = 1'b0;
    check(hit == 1'b1 && kills == 8'd1 && lane == 16'h0, "hit_pos2", {hit, kills, lane}, {1'b1, 8'd1, 16'h0});
    tick();
    check(hit == 1'b0 && lane == 16'h0, "hit_one_cycle", {hit, lane}, 0);

    // 3: attack coincident with pos-0 expiry
    wait_lane(16'h0001, 600, n);
    tick(); tick(); tick();
    check(lane == 16'h0001 && damage == 1'b0, "pos0_before_expiry", {damage, lane}, 16'h0001);
    exp_q.push_back('{dmg: 1'b0, kills: 8'd2});
    attack = 1'b1; tick(); attack = 1'b0;
    check(hit == 1'b1 && damage == 1'b0 && kills == 8'd2, "hit_beats_damage", {hit, damage, kills}, {1'b1, 1'b0, 8'd2});

    // 4: game_over freezes, async reset clears
    wait_lane(16'h0080, 600, n);
    game_over = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      attack = i[0];
      tick();
      check(lane == 16'h0080 && hit == 1'b0 && damage == 1'b0 && kills == 8'd2, "halt_frozen",
            {lane, kills, hit, damage}, {16'h0080, 8'd2, 2'b00});
    end
    attack = 1'b0;
    rst_n = 1'b0;
    #2;
    check({lane, kills, hit, damage} == 26'd0, "async_reset", {lane, kills, hit, damage}, 0);
    game_over = 1'b0;
    tick();
    rst_n = 1'b1;

    // 5/6: step period per kill count, saturation at 255, held attack is one hit
    for (int k = 0; k < 256; k++) begin
      wait_lane(16'h8000, 600, n);
      per = 0;
      while (lane === 16'h8000 && per < 40) begin tick(); per++; end
      check(per == exp_period(k), "step_period", per, exp_period(k));
      wait_lane(16'h0008, 100, n);
      exp_q.push_back('{dmg: 1'b0, kills: (k >= 255) ? 8'd255 : 8'(k + 1)});
      attack = 1'b1;
      tick();
      if (k == 0) begin tick(); tick(); tick(); tick(); end
      attack = 1'b0;
    end
    check(kills == 8'd255, "kills_saturated", kills, 255);

    // game_over with a qualifying attack: one hit, then halt
    wait_lane(16'h0008, 700, n);
    exp_q.push_back('{dmg: 1'b0, kills: 8'd255});
    attack = 1'b1; game_over = 1'b1;
    tick();
    attack = 1'b0;
    check(hit == 1'b1 && lane == 16'h0, "hit_with_game_over", {hit, lane}, {1'b1, 16'h0});
    tick();
    check(hit == 1'b0 && lane == 16'h0, "halt_after_hit", {hit, lane}, 0);
    repeat (300) tick();
    check(lane == 16'h0 && kills == 8'd255, "halt_no_respawn", {lane, kills}, {16'h0, 8'd255});
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
